fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side controller for the signed-word `fifo`. It issues `read` pulses into the FIFO only when it is not empty and there is downstream room, and captures the FIFO's registered `data_out` one cycle later into a 2-entry output buffer. It presents the words on a valid/ready stream with a per-burst `m_last` marker. It sits between a `fifo` instance and any consumer that applies backpressure, such as the requantisation and output-packing stages of the accelerator datapath.

## Interface
- `D_W`, 32, word width; matches the paired `fifo`.
- `BURST_LEN`, 8, number of words per burst; `m_last` marks the final word of each burst; minimum 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `enable`  in  1  when 1, new FIFO reads may be issued; when 0, in-flight words still complete.
- `fifo_empty`  in  1  `empty` flag of the paired FIFO.
- `fifo_data`  in  D_W (signed)  `data_out` of the paired FIFO; valid the cycle after `fifo_read`.
- `fifo_read`  out  1  `read` strobe to the FIFO; combinational.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word when `m_valid && m_ready`.
- `m_data`  out  D_W (signed)  output word, taken from the head of the buffer.
- `m_last`  out  1  the current word is beat `BURST_LEN` of its burst.
- `busy`  out  1  high while a read is in flight or the buffer holds data.

## Operation
- State elements:
  - `inflight` (1 bit): a read was issued last cycle.
  - `count` (0..2): buffer occupancy.
  - 2-entry buffer with head and tail pointers.
  - `beat` counter of width `$clog2(BURST_LEN)` bits, minimum 1 bit.
- `pop = m_valid && m_ready`.
- `fifo_read = enable && !fifo_empty && (count + inflight - pop) < 2`. This is the credit rule: a word may be captured only when it has a guaranteed slot.
- `fifo_read` is never asserted while `fifo_empty` is 1. The FIFO must never underflow.
- Capture: when `inflight` is 1, `fifo_data` is written to the buffer tail and `count` increments, unless a pop occurs in the same cycle.
- Simultaneous capture and pop: `count` is unchanged, both pointers advance, and the head moves to the next entry.
- `m_valid = (count != 0)`. `m_data` is the head entry.
- Beat counting: on each pop, `beat` increments. It wraps to 0 after `BURST_LEN-1`.
- `m_last = m_valid && (beat == BURST_LEN-1)`. With `BURST_LEN == 1`, every word is last.
- Dropping `enable` blocks new reads only. An outstanding `inflight` word is still captured and delivered.
- `busy = inflight || (count != 0)`.
- Reset (asynchronous, `rst` = 1):
  - `inflight`, `count`, both pointers and `beat` clear to 0.
  - `m_valid`, `m_last` and `busy` drop to 0 immediately.
  - `m_data` reads 0: buffer entries clear to 0.
  - A word returned by the FIFO after reset is discarded. Because `inflight` is cleared, it is never captured.
- The FIFO's own pointers are reset by the same `rst` at system level. The reader does not resynchronise them.

## Timing
- Cycle t: `fifo_read` = 1. The FIFO decrements its occupancy at the end of t.
- Cycle t+1: `fifo_data` valid and `inflight` = 1. The word is captured at the end of t+1.
- Cycle t+2: `m_valid` = 1. Minimum latency from `fifo_read` to `m_valid` is 2 cycles.
- With `m_ready` held at 1 and a non-empty FIFO, steady-state throughput is 1 word per cycle:
  - the pipeline holds `count` = 1 and `inflight` = 1;
  - the pop in each cycle frees a slot for the next read.
- When `m_ready` stalls, at most 2 words are buffered plus 0 in flight. `fifo_read` stays 0 until a pop occurs.
- `fifo_empty` is re-evaluated every cycle with no stale-flag hazard. The FIFO updates occupancy on the same edge that samples `read`, and `fifo_read` is combinational.
- `m_data`, `m_valid` and `m_last` are held stable while `m_valid && !m_ready`.

## Test plan
- Single word: write value -5 into an empty FIFO with `enable` = 1 and `m_ready` = 1.
  - `fifo_read` pulses once.
  - `m_valid` and `m_data` = -5 appear 2 cycles later for exactly 1 cycle.
  - `busy` then falls to 0.
- Streaming: preload 16 words (values 0..15), hold `m_ready` = 1, `BURST_LEN` = 4.
  - `fifo_read` is high for 16 consecutive cycles.
  - Words 0..15 appear on consecutive cycles, in order.
  - `m_last` is high on words 3, 7, 11 and 15.
- Backpressure: preload 8 words, hold `m_ready` = 0 for 10 cycles, then release it.
  - `count` saturates at 2 and reads stop after 2.
  - No `fifo_read` is issued while stalled.
  - After release, all 8 words arrive in order with no loss or duplication.
- Enable gating: stream 8 words, drop `enable` after the 3rd `fifo_read`.
  - Exactly 3 words are delivered.
  - The FIFO retains 5 words.
  - Re-raising `enable` delivers the remaining 5, with `m_last` positions continuing the burst count.
- Empty and underflow: alternate FIFO writes and stalls so `fifo_empty` toggles, and randomise `m_ready`.
  - `fifo_read && fifo_empty` is never true.
  - The output sequence equals the input sequence.
- Asynchronous reset mid-burst: assert `rst` between clock edges while `count` = 2 and `inflight` = 1.
  - `m_valid`, `m_last`, `busy` and `m_data` go to 0 before the next edge.
  - The in-flight word is not delivered.
  - `beat` restarts at 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the signed-word fifo: credit-gated read strobes,
// a 2-entry capture buffer and a valid/ready output stream with burst markers.
module fifo_stream_reader #(
  parameter int D_W       = 32,
  parameter int BURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic signed [D_W-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [D_W-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic                  inflight;
  logic [1:0]            count;
  logic                  head;
  logic                  tail;
  logic signed [D_W-1:0] buffer [2];
  logic [BEAT_W-1:0]     beat;
  logic                  pop;
  logic [2:0]            credit;

  assign m_valid = (count != 2'd0);
  assign m_data  = buffer[head];
  assign m_last  = m_valid && (beat == LAST_BEAT);
  assign busy    = inflight || (count != 2'd0);

  // A read is issued only if the word it returns is guaranteed a buffer slot
  // after this cycle's pop, so the buffer can never overflow.
  always_comb begin
    pop       = m_valid && m_ready;
    credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    fifo_read = enable && !fifo_empty && (credit < 3'd2);
  end

  // NOTE: the buffer entries are reset too, so m_data reads 0 while in reset
  // instead of exposing stale words; this costs reset fan-out on 2*D_W flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
      beat     <= '0;
      for (int i = 0; i < 2; i++) buffer[i] <= '0;
    end else begin
      inflight <= fifo_read;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        buffer[tail] <= fifo_data;
        tail         <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
      end
    end
  end

endmodule
